// File: rtl/path_select.sv
// Genetic path search selection stage: scores every path by walking its genes toward a fixed
// target, keeps the SEL_N best in a sorted list, then copies them out rank-ordered.
// Optional best_score output is enabled with `define SELECT_BEST_SCORE_EN.
module path_select #(
  parameter int NUM_PATHS = 50,
  parameter int SEL_N     = 10,
  parameter int PATH_BITS = 150,
  parameter int TGT_X     = 20,
  parameter int TGT_Y     = 21
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_PATHS*PATH_BITS-1:0] population,
  output logic [SEL_N*PATH_BITS-1:0]     sel_population,
  output logic                           busy,
  output logic                           done
`ifdef SELECT_BEST_SCORE_EN
  ,
  output logic [8:0]                     best_score
`endif
);
  localparam int GENES  = PATH_BITS / 2;
  localparam int IDX_W  = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1;
  localparam int GENE_W = (GENES > 1) ? $clog2(GENES) : 1;
  localparam int RANK_W = (SEL_N > 1) ? $clog2(SEL_N) : 1;
  localparam int PB_W   = $clog2(PATH_BITS);
  localparam int POP_AW = $clog2(NUM_PATHS * PATH_BITS);
  localparam int SEL_AW = $clog2(SEL_N * PATH_BITS);

  typedef enum logic [1:0] {IDLE, SCORE, INSERT, COPY} state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             path_q, path_d;
  logic [GENE_W-1:0]            gene_q, gene_d;
  logic [RANK_W-1:0]            rank_q, rank_d;
  logic signed [7:0]            x_q, x_d, y_q, y_d;
  logic [SEL_N-1:0][8:0]        lst_score_q, lst_score_d;
  logic [SEL_N-1:0][IDX_W-1:0]  lst_idx_q, lst_idx_d;
  logic [SEL_N*PATH_BITS-1:0]   sel_q, sel_d;
  logic                         busy_q, busy_d, done_q, done_d;
`ifdef SELECT_BEST_SCORE_EN
  logic [8:0]                   best_q, best_d;
`endif

  logic [POP_AW-1:0]    pbase, cbase;
  logic [SEL_AW-1:0]    rbase;
  logic [PATH_BITS-1:0] cur_path;
  logic [PB_W-1:0]      gsel;
  logic [1:0]           gene_bits;
  logic signed [9:0]    dx, dy;
  logic [9:0]           adx, ady;
  logic [8:0]           new_score;
  logic [SEL_N-1:0]     lt;

  always_comb begin
    pbase     = POP_AW'(path_q) * POP_AW'(PATH_BITS);
    cbase     = POP_AW'(lst_idx_q[rank_q]) * POP_AW'(PATH_BITS);
    rbase     = SEL_AW'(rank_q) * SEL_AW'(PATH_BITS);
    cur_path  = population[pbase +: PATH_BITS];
    gsel      = PB_W'({gene_q, 1'b0});
    gene_bits = cur_path[gsel +: 2];
    dx        = 10'(x_q) - 10'(TGT_X);
    dy        = 10'(y_q) - 10'(TGT_Y);
    adx       = dx[9] ? 10'(-dx) : 10'(dx);
    ady       = dy[9] ? 10'(-dy) : 10'(dy);
    new_score = 9'(adx + ady);
    for (int j = 0; j < SEL_N; j++) lt[j] = new_score < lst_score_q[j];
  end

  always_comb begin
    state_d     = state_q;
    path_d      = path_q;
    gene_d      = gene_q;
    rank_d      = rank_q;
    x_d         = x_q;
    y_d         = y_q;
    lst_score_d = lst_score_q;
    lst_idx_d   = lst_idx_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef SELECT_BEST_SCORE_EN
    best_d      = best_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d     = SCORE;
        path_d      = '0;
        gene_d      = '0;
        x_d         = '0;
        y_d         = '0;
        lst_score_d = '1;
        lst_idx_d   = '0;
        busy_d      = 1'b1;
      end
      SCORE: begin
        case (gene_bits)
          2'b00:   y_d = y_q + 8'sd1;
          2'b01:   x_d = x_q + 8'sd1;
          2'b10:   y_d = y_q - 8'sd1;
          default: x_d = x_q - 8'sd1;
        endcase
        gene_d = gene_q + 1'b1;
        if (gene_q == GENE_W'(GENES - 1)) state_d = INSERT;
      end
      INSERT: begin
        // The list is kept ascending, so lt is a thermometer code: the first set bit is the
        // insertion slot and every set bit above it takes its predecessor's entry.
        if (lt[0]) begin
          lst_score_d[0] = new_score;
          lst_idx_d[0]   = path_q;
        end
        for (int j = 1; j < SEL_N; j++) begin
          if (lt[j-1]) begin
            lst_score_d[j] = lst_score_q[j-1];
            lst_idx_d[j]   = lst_idx_q[j-1];
          end else if (lt[j]) begin
            lst_score_d[j] = new_score;
            lst_idx_d[j]   = path_q;
          end
        end
        gene_d = '0;
        x_d    = '0;
        y_d    = '0;
        if (path_q == IDX_W'(NUM_PATHS - 1)) begin
          state_d = COPY;
          rank_d  = '0;
        end else begin
          state_d = SCORE;
          path_d  = path_q + 1'b1;
        end
      end
      default: begin
        sel_d[rbase +: PATH_BITS] = population[cbase +: PATH_BITS];
        rank_d = rank_q + 1'b1;
        if (rank_q == RANK_W'(SEL_N - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SELECT_BEST_SCORE_EN
          best_d  = lst_score_q[0];
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      path_q      <= '0;
      gene_q      <= '0;
      rank_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      lst_score_q <= '1;
      lst_idx_q   <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SELECT_BEST_SCORE_EN
      best_q      <= 9'h1FF;
`endif
    end else begin
      state_q     <= state_d;
      path_q      <= path_d;
      gene_q      <= gene_d;
      rank_q      <= rank_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lst_score_q <= lst_score_d;
      lst_idx_q   <= lst_idx_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SELECT_BEST_SCORE_EN
      best_q      <= best_d;
`endif
    end
  end

  assign sel_population = sel_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef SELECT_BEST_SCORE_EN
  assign best_score     = best_q;
`endif
endmodule

// File: tb/tb_path_select.sv
// Directed bench for path_select: tie order, single winner, strictly ranked population,
// ignored restarts, mid-run reset and optional best_score.
module tb_path_select;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7499:0] pop = '0;
  logic [1499:0] sel;
  logic          busy, done;
`ifdef SELECT_BEST_SCORE_EN
  logic [8:0]    best;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  path_select dut (
    .clk(clk), .rst_n(rst_n), .start(start), .population(pop),
    .sel_population(sel), .busy(busy), .done(done)
`ifdef SELECT_BEST_SCORE_EN
    , .best_score(best)
`endif
  );

  task automatic check(input string tag, input logic [149:0] obs, input logic [149:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walk to (bx,by) with x moves, then y moves, then cancelling (x+1,x-1) pairs.
  function automatic logic [149:0] build_path(input int bx, input int by);
    logic [149:0] p = '0;
    int g = 0;
    for (int k = 0; k < (bx < 0 ? -bx : bx); k++) begin
      p |= 150'(bx < 0 ? 2'b11 : 2'b01) << (2 * g); g++;
    end
    for (int k = 0; k < (by < 0 ? -by : by); k++) begin
      p |= 150'(by < 0 ? 2'b10 : 2'b00) << (2 * g); g++;
    end
    while (g < 75) begin
      p |= 150'(2'b01) << (2 * g);
      p |= 150'(2'b11) << (2 * g + 2);
      g += 2;
    end
    return p;
  endfunction

  // Score of path i is 2*(49-i): strictly decreasing with index.
  function automatic logic [149:0] ranked_path(input int i);
    return build_path(20 - (49 - i), 21 - (49 - i));
  endfunction

  // Gene-order rotation keeps the end point, so all these tie at score 0 yet differ.
  function automatic logic [149:0] rot_path(input int i);
    logic [149:0] b = build_path(20, 21);
    if (i == 0) return b;
    return (b >> (2 * i)) | (b << (150 - 2 * i));
  endfunction

  task automatic run(input string tag, input int e1, input int e2);
    int n = 0;
    int gap = 0;
    bit got = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got && n < 5000) begin
      start = ((n + 1) == e1) || ((n + 1) == e2);
      @(posedge clk); #1;
      n++;
      if (done) got = 1;
      else if (!busy) gap++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 150'(n), 150'(3810));
    check({tag, "_busy_gap"}, 150'(gap), 150'(0));
    check({tag, "_busy_end"}, 150'(busy), 150'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 150'(done), 150'(0));
  endtask

  task automatic check_sel(input string tag, input logic [1499:0] exp);
    for (int r = 0; r < 10; r++)
      check($sformatf("%s_rank%0d", tag, r), 150'(sel >> (150 * r)), 150'(exp >> (150 * r)));
  endtask

  initial begin
    logic [1499:0] exp;
    #12;
    check("rst_busy", 150'(busy), 150'(0));
    check("rst_done", 150'(done), 150'(0));
    check("rst_sel", 150'(sel == '0), 150'(1));
`ifdef SELECT_BEST_SCORE_EN
    check("rst_best", 150'(best), 150'(9'h1FF));
`endif
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero population: every path scores 74, ties keep paths 0..9.
    pop = '0;
    run("zero", 0, 0);
    check_sel("zero", '0);
`ifdef SELECT_BEST_SCORE_EN
    check("zero_best", 150'(best), 150'(74));
`endif

    // Path 37 hits the target exactly; the zero paths follow in index order.
    pop = '0;
    pop |= 7500'(build_path(20, 21)) << (150 * 37);
    run("win37", 0, 0);
    check_sel("win37", 1500'(build_path(20, 21)));
`ifdef SELECT_BEST_SCORE_EN
    check("win37_best", 150'(best), 150'(0));
`endif

    // Strictly ranked population with stray starts that must be ignored.
    pop = '0;
    for (int i = 0; i < 50; i++) pop |= 7500'(ranked_path(i)) << (150 * i);
    exp = '0;
    for (int r = 0; r < 10; r++) exp |= 1500'(ranked_path(49 - r)) << (150 * r);
    run("ranked", 5, 2000);
    check_sel("ranked", exp);
`ifdef SELECT_BEST_SCORE_EN
    check("ranked_best", 150'(best), 150'(0));
`endif

    // Reset mid-run clears outputs asynchronously; a fresh run on distinct ties follows.
    pop = '0;
    for (int i = 0; i < 50; i++) pop |= 7500'(rot_path(i)) << (150 * i);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1000) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 150'(busy), 150'(0));
    check("abort_done", 150'(done), 150'(0));
    check("abort_sel", 150'(sel == '0), 150'(1));
`ifdef SELECT_BEST_SCORE_EN
    check("abort_best", 150'(best), 150'(9'h1FF));
`endif
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp = '0;
    for (int r = 0; r < 10; r++) exp |= 1500'(rot_path(r)) << (150 * r);
    run("tie", 0, 0);
    check_sel("tie", exp);
`ifdef SELECT_BEST_SCORE_EN
    check("tie_best", 150'(best), 150'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/path_select.md
# path_select

Selection stage of the genetic path search. It sits between the population state holder and the mutation stage. It scores every 150-bit path in the current population by simulating its grid walk against a fixed target, then keeps the SEL_N best paths. It emits them, rank-ordered, as the packed selected population that the mutation stage consumes.

## Interface
- NUM_PATHS, 50: paths in population (≥ SEL_N)
- SEL_N, 10: paths kept (20 %)
- PATH_BITS, 150: bits per path = 75 genes × 2 bits
- TGT_X, 20: signed target x, range −64..63
- TGT_Y, 21: signed target y, range −64..63

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- population  in  NUM_PATHS*PATH_BITS  path i at [PATH_BITS*i +: PATH_BITS]; must stay stable while busy
- sel_population  out  SEL_N*PATH_BITS  rank r (0 = best) at [PATH_BITS*r +: PATH_BITS]
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse, sel_population valid
- best_score  out  9  rank-0 score (only with SELECT_BEST_SCORE_EN)

## Operation
- Gene k of a path = bits [2k+1:2k].
- Gene moves:
  - 00 → y+1
  - 01 → x+1
  - 10 → y−1
  - 11 → x−1
- Walk starts at (0,0). x and y are 8-bit signed.
- score = |x−TGT_X| + |y−TGT_Y|, 9-bit unsigned; lower is better.
- Sorted list of SEL_N entries {score[8:0], index[5:0]}; cleared to score 9'h1FF on start.
- Insert: new entry goes at the first position j where new score < entry[j].score (strict). Entries j..SEL_N−2 shift down and the last entry drops. Ties therefore keep the lower path index first.
- FSM:
  - IDLE: start → SCORE. Clears path=0, gene=0, x=y=0, clears the list, busy←1.
  - SCORE: applies one gene per cycle. After gene 74 → INSERT.
  - INSERT: inserts the entry, then path++. If path was NUM_PATHS−1 → COPY, else SCORE with gene and x/y cleared.
  - COPY: copies population path list[r].index into sel_population rank r, one rank per cycle, r = 0..SEL_N−1. On the last rank: done←1, busy←0, → IDLE.
- start while not IDLE is ignored.
- sel_population holds its value until the next COPY overwrites it.

## Timing
- Reset values:
  - sel_population = 0, busy = 0, done = 0, best_score = 9'h1FF
  - FSM in IDLE, list cleared
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is retained.
- Call the edge that accepts start edge 0.
  - Path p is inserted at edge 76(p+1).
  - The last insert is at edge 3800.
  - COPY runs on edges 3801..3810.
- done is registered high after edge 3810 and cleared at edge 3811. Latency is 3810 cycles for the defaults; in general NUM_PATHS·76 + SEL_N.
- busy is high after edge 0 through edge 3810.
- A new start is accepted on edge 3811 or later. A start coincident with done's cycle is accepted, since the FSM is already in IDLE.

## Configuration
- SELECT_BEST_SCORE_EN defined:
  - best_score port exists.
  - It loads list[0].score on the same edge that sets done, and holds it otherwise.
  - Reset value is 9'h1FF.
- Not defined:
  - Port is absent and no best_score register is built.
  - All other behaviour is identical.

## Test plan
- All-zero population (every path walks to (0,75), score 20+54=74), one start → done 3810 cycles later; sel_population == population[1499:0] (paths 0..9, tie order).
- Path 37 = 20×01, 21×00, 17×(01,11) (score 0); all other paths zero → rank 0 = path 37, ranks 1..9 = paths 0..8.
- Paths built so that score strictly decreases with index → ranks 0..9 = paths 49,48,…,40.
- Extra start pulses at cycles 5 and 2000 after acceptance → ignored; exactly one done at 3810; busy continuous.
- rst_n low at cycle 1000 → busy=0, done=0, sel_population=0 asynchronously; a fresh start then completes at 3810 with correct result.
- With SELECT_BEST_SCORE_EN, scenario 2 → best_score=0 when done rises; scenario 1 → 74; 9'h1FF after reset.
